mc_controller: RTL



---
 rtl/riscv_ctrl_pkg.sv | 54 +++++
 rtl/mc_controller_if.sv | 35 +++
 rtl/branch_cond.sv | 24 ++
 rtl/mc_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes and
// the datapath select/ALU-op codes the controller drives.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JALR, JAL, LUI, AUIPC, TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;
   localparam logic [1:0] ALU_IMM = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Immediate format follows the opcode alone; unknown opcodes fall back to I.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle. master is the controller side,
// slave is the datapath side.
interface mc_controller_if #(parameter int CNT_W = 32);
   logic [6:0]       op;
   logic [2:0]       funct3;
   logic             zero;
   logic             lt;
   logic             ltu;
   logic             mem_ready;
   logic             pc_write;
   logic             adr_src;
   logic             mem_write;
   logic             ir_write;
   logic [1:0]       result_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [2:0]       imm_src;
   logic             reg_write;
   logic             illegal;
   logic             retire;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, funct3, zero, lt, ltu, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, imm_src, reg_write, illegal, retire, instret
   );

   modport slave (
      output op, funct3, zero, lt, ltu, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_op, imm_src, reg_write, illegal, retire, instret
   );
endinterface

// File: rtl/branch_cond.sv
// Branch resolution from ALU compare flags; valid drops for the two funct3
// codes RV32I leaves unassigned.
module branch_cond (
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken,
   output logic       valid
);
   always_comb begin
      taken = 1'b0;
      valid = 1'b1;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = lt;
         3'b101:  taken = !lt;
         3'b110:  taken = ltu;
         3'b111:  taken = !ltu;
         default: valid = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I main controller: sequences ALU, memory, register file and
// PC, resolves branches, traps on illegal encodings and counts retirements.
module mc_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mc_controller_if.master   bus
);
   state_t           state, next;
   logic [CNT_W-1:0] instret_q;
   logic             taken, f3_valid;
   logic             pc_write_c, ir_write_c, mem_write_c, reg_write_c, retire_c;

   branch_cond u_branch_cond (
      .funct3 (bus.funct3),
      .zero   (bus.zero),
      .lt     (bus.lt),
      .ltu    (bus.ltu),
      .taken  (taken),
      .valid  (f3_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        instret_q <= '0;
      else if (retire_c) instret_q <= instret_q + CNT_W'(1);
   end

   always_comb begin
      next           = state;
      pc_write_c     = 1'b0;
      ir_write_c     = 1'b0;
      mem_write_c    = 1'b0;
      reg_write_c    = 1'b0;
      retire_c       = 1'b0;
      bus.adr_src    = 1'b0;
      bus.result_src = RES_ALUOUT;
      bus.alu_src_a  = A_PC;
      bus.alu_src_b  = B_RS2;
      bus.alu_op     = ALU_ADD;
      case (state)
         FETCH: begin
            bus.alu_src_b  = B_FOUR;
            bus.result_src = RES_ALU;
            ir_write_c     = bus.mem_ready;
            pc_write_c     = bus.mem_ready;
            if (bus.mem_ready) next = DECODE;
         end
         DECODE: begin
            bus.alu_src_a = A_OLDPC;
            bus.alu_src_b = B_IMM;
            case (bus.op)
               OP_LOAD, OP_STORE: next = MEMADR;
               OP_R:              next = EXECR;
               OP_I:              next = EXECI;
               OP_BRANCH:         next = f3_valid ? BRANCH : TRAP;
               OP_JAL:            next = JAL;
               OP_JALR:           next = JALR;
               OP_LUI:            next = LUI;
               OP_AUIPC:          next = AUIPC;
               default:           next = TRAP;
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = A_RS1;
            bus.alu_src_b = B_IMM;
            next          = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            bus.adr_src = 1'b1;
            if (bus.mem_ready) next = MEMWB;
         end
         MEMWB: begin
            bus.result_src = RES_RDATA;
            reg_write_c    = 1'b1;
            retire_c       = 1'b1;
            next           = FETCH;
         end
         MEMWRITE: begin
            bus.adr_src = 1'b1;
            mem_write_c = 1'b1;
            if (bus.mem_ready) begin
               retire_c = 1'b1;
               next     = FETCH;
            end
         end
         EXECR: begin
            bus.alu_src_a = A_RS1;
            bus.alu_op    = ALU_FN;
            next          = ALUWB;
         end
         EXECI: begin
            bus.alu_src_a = A_RS1;
            bus.alu_src_b = B_IMM;
            bus.alu_op    = ALU_FN;
            next          = ALUWB;
         end
         ALUWB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
            next        = FETCH;
         end
         BRANCH: begin
            // ALUOut still holds the target computed in DECODE
            bus.alu_src_a = A_RS1;
            bus.alu_op    = ALU_BR;
            pc_write_c    = taken;
            retire_c      = 1'b1;
            next          = FETCH;
         end
         JALR: begin
            bus.alu_src_a = A_RS1;
            bus.alu_src_b = B_IMM;
            next          = JAL;
         end
         JAL: begin
            // PC takes ALUOut while the ALU forms the link value OldPC+4
            bus.alu_src_a = A_OLDPC;
            bus.alu_src_b = B_FOUR;
            pc_write_c    = 1'b1;
            next          = ALUWB;
         end
         LUI: begin
            bus.alu_src_a = A_RS1;
            bus.alu_src_b = B_IMM;
            bus.alu_op    = ALU_IMM;
            next          = ALUWB;
         end
         AUIPC: begin
            bus.alu_src_a = A_OLDPC;
            bus.alu_src_b = B_IMM;
            next          = ALUWB;
         end
         TRAP:    next = TRAP;
         default: next = FETCH;
      endcase
   end

   // Enables are gated by reset so a mid-access reset drops them at once.
   assign bus.pc_write  = rst_n & pc_write_c;
   assign bus.ir_write  = rst_n & ir_write_c;
   assign bus.mem_write = rst_n & mem_write_c;
   assign bus.reg_write = rst_n & reg_write_c;
   assign bus.retire    = rst_n & retire_c;
   assign bus.illegal   = (state == TRAP);
   assign bus.imm_src   = imm_src_of(bus.op);
   assign bus.instret   = instret_q;

endmodule
